// File: rtl/mem_sram_ctrl.sv
// MEM-stage SRAM controller: one 32-bit word access becomes two
// 16-bit SRAM half-accesses, with ready held low while busy.
module mem_sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_Res,
  input  logic [31:0] Val_Rm,
  output logic [31:0] Read_Data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  localparam int unsigned CW =
    (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(WAIT_CYCLES - 1);

  state_t      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic        req, rd, wr;
  logic        term, active, half, drive;
  logic [31:0] off;
  logic [15:0] wdata;
  logic        unused_bits;

  // A simultaneous read and write is treated as a write.
  assign req  = MEM_R_EN | MEM_W_EN;
  assign wr   = MEM_W_EN;
  assign rd   = MEM_R_EN & ~MEM_W_EN;
  assign off  = ALU_Res - BASE_ADDR;
  assign term = (cnt == TERM);

  // Byte lane bits and the out-of-range top bits do not reach the pins.
  assign unused_bits = ^{off[31:19], off[1:0]};

  // State and wait counter; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state, wait counting and handshake decode.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ready   = 1'b0;
    active  = 1'b0;
    half    = 1'b0;
    unique case (state)
      IDLE: begin
        ready = ~req;
        if (req) begin
          state_n = LOW;
          cnt_n   = '0;
        end
      end
      LOW: begin
        active = 1'b1;
        if (term) begin
          state_n = HIGH;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HIGH: begin
        active = 1'b1;
        half   = 1'b1;
        if (term) begin
          state_n = DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  assign SRAM_ADDR = active ? {off[18:2], half} : '0;
  assign drive     = active & wr;
  assign SRAM_WE_N = ~drive;
  assign wdata     = half ? Val_Rm[31:16] : Val_Rm[15:0];
  assign SRAM_DQ   = drive ? wdata : 16'hzzzz;

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  // Load data: each half is captured on the last wait cycle of its phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Read_Data <= '0;
    end else if (rd && active && term) begin
      if (half) Read_Data[31:16] <= SRAM_DQ;
      else      Read_Data[15:0]  <= SRAM_DQ;
    end
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl: vector table of word accesses
// against a behavioural SRAM, plus reset-abort sequences.
module tb_mem_sram_ctrl;

  localparam int W = 2;

  logic        clk;
  logic        rst;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] alu_res;
  logic [31:0] val_rm;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic        sram_ub_n;
  logic        sram_lb_n;
  logic        sram_ce_n;
  logic        sram_oe_n;

  logic [15:0] mem [0:262143];

  int total;
  int passed;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] lo;
    logic [31:0] exp_rd;
    logic        chain;
  } vec_t;

  vec_t vecs [9];

  mem_sram_ctrl #(
    .WAIT_CYCLES(W),
    .BASE_ADDR  (32'd1024)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .MEM_R_EN (mem_r_en),
    .MEM_W_EN (mem_w_en),
    .ALU_Res  (alu_res),
    .Val_Rm   (val_rm),
    .Read_Data(read_data),
    .ready    (ready),
    .SRAM_DQ  (sram_dq),
    .SRAM_ADDR(sram_addr),
    .SRAM_WE_N(sram_we_n),
    .SRAM_UB_N(sram_ub_n),
    .SRAM_LB_N(sram_lb_n),
    .SRAM_CE_N(sram_ce_n),
    .SRAM_OE_N(sram_oe_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM: drives the bus whenever not being written.
  assign sram_dq = sram_we_n ? mem[sram_addr] : 16'hzzzz;

  // SRAM write port.
  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr] <= sram_dq;
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    else
      passed++;
  endtask

  task automatic access(input int i, input vec_t v);
    logic        hi;
    logic [15:0] dexp;
    @(negedge clk);
    mem_r_en = v.rd;
    mem_w_en = v.wr;
    alu_res  = v.addr;
    val_rm   = v.wdata;
    #1;
    check($sformatf("v%0d c0 ready", i), {31'd0, ready}, 32'd0);
    for (int k = 1; k <= 2 * W + 1; k++) begin
      @(negedge clk);
      check($sformatf("v%0d c%0d ready", i, k),
            {31'd0, ready}, {31'd0, (k == 2 * W + 1)});
      if (k <= 2 * W) begin
        hi   = (k > W);
        dexp = hi ? v.wdata[31:16] : v.wdata[15:0];
        check($sformatf("v%0d c%0d addr", i, k),
              {14'd0, sram_addr}, {14'd0, v.lo + {17'd0, hi}});
        check($sformatf("v%0d c%0d we_n", i, k),
              {31'd0, sram_we_n}, {31'd0, ~v.wr});
        if (v.wr)
          check($sformatf("v%0d c%0d dq", i, k),
                {16'd0, sram_dq}, {16'd0, dexp});
      end else begin
        check($sformatf("v%0d rdata", i), read_data, v.exp_rd);
      end
    end
  endtask

  initial begin
    total    = 0;
    passed   = 0;
    rst      = 1'b1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    alu_res  = '0;
    val_rm   = '0;
    for (int a = 0; a < 262144; a++) mem[a] = 16'h0000;

    vecs[0] = '{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF,
                18'h00004, 32'h00000000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'd1032, 32'h0,
                18'h00004, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'd1036, 32'h12345678,
                18'h00006, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'd1036, 32'h0,
                18'h00006, 32'h12345678, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 32'd1020, 32'hCAFEF00D,
                18'h3FFFE, 32'h12345678, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'd1020, 32'h0,
                18'h3FFFE, 32'hCAFEF00D, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'd1035, 32'h0,
                18'h00004, 32'hDEADBEEF, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 32'd1024, 32'hAAAA5555,
                18'h00000, 32'hDEADBEEF, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 32'd1024, 32'h0,
                18'h00000, 32'hAAAA5555, 1'b0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst ready", {31'd0, ready}, 32'd1);
    check("rst we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst addr", {14'd0, sram_addr}, 32'd0);
    check("rst rdata", read_data, 32'd0);
    check("rst dq", {16'd0, sram_dq}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      access(i, vecs[i]);
      if (!vecs[i].chain) begin
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d idle ready", i), {31'd0, ready}, 32'd1);
        check($sformatf("v%0d idle addr", i),
              {14'd0, sram_addr}, 32'd0);
      end
    end

    // Reset in the middle of a load, after the low half landed.
    @(negedge clk);
    mem_r_en = 1'b1;
    alu_res  = 32'd1036;
    repeat (3) @(negedge clk);
    check("ld partial rdata", read_data, 32'hAAAA5678);
    check("ld partial addr", {14'd0, sram_addr}, 32'd7);
    #2 rst = 1'b1;
    #1;
    check("ld rst rdata", read_data, 32'd0);
    check("ld rst addr", {14'd0, sram_addr}, 32'd0);
    check("ld rst ready req", {31'd0, ready}, 32'd0);
    mem_r_en = 1'b0;
    #1;
    check("ld rst ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a store must release the bus.
    @(negedge clk);
    mem_w_en = 1'b1;
    alu_res  = 32'd1040;
    val_rm   = 32'h11112222;
    @(negedge clk);
    check("st addr", {14'd0, sram_addr}, 32'd8);
    check("st we_n", {31'd0, sram_we_n}, 32'd0);
    check("st dq", {16'd0, sram_dq}, 32'h2222);
    #2 rst = 1'b1;
    #1;
    check("st rst we_n", {31'd0, sram_we_n}, 32'd1);
    check("st rst addr", {14'd0, sram_addr}, 32'd0);
    check("st rst dq", {16'd0, sram_dq}, 32'h5555);
    mem_w_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("st rst ready", {31'd0, ready}, 32'd1);
    check("st no write", {16'd0, mem[8]}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
